partita_stats: RTL and testbench
================================

PARTITA_STATS -- requirements
Module: partita_stats

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset, named clk and rst_n.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock shared with the MorraCinese FSMD.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port INIZIO, input, 1 bit: match-start strobe, the same signal that drives the FSMD.
REQ-005 SHALL have port MANCHE, input, 2 bits: FSMD round result; 00 none, 01 PRIMO wins, 10 SECONDO wins, 11 draw.
REQ-006 SHALL have port PARTITA, input, 2 bits: FSMD match result; 00 in progress, 01 PRIMO wins, 10 SECONDO wins, 11 draw.
REQ-007 SHALL have port RD_REQ, input, 1 bit: pop request for the history FIFO.
REQ-008 SHALL have port VITTORIE_1, output, 4 bits: matches won by PRIMO.
REQ-009 SHALL have port VITTORIE_2, output, 4 bits: matches won by SECONDO.
REQ-010 SHALL have port PAREGGI, output, 4 bits: drawn matches.
REQ-011 SHALL have port N_MANCHE, output, 5 bits: valid rounds played in the current match.
REQ-012 SHALL have port STATO, output, 2 bits: 00 IDLE, 01 IN_GIOCO, 10 FINITA.
REQ-013 SHALL have port HIST_DATA, output, 2 bits: popped match result.
REQ-014 SHALL have port HIST_VALID, output, 1 bit: HIST_DATA is valid this cycle.
REQ-015 SHALL have ports HIST_EMPTY and HIST_FULL, outputs, 1 bit each: FIFO status flags.

Function
REQ-016 SHALL sample all inputs on the rising edge of clk; all outputs SHALL be registered.
REQ-017 In IDLE, INIZIO=1 SHALL transition to IN_GIOCO and clear N_MANCHE; all other inputs SHALL be ignored.
REQ-018 In IN_GIOCO, MANCHE!=00 SHALL increment N_MANCHE by 1, saturating at 31.
REQ-019 In IN_GIOCO, PARTITA!=00 SHALL increment the matching counter (01 -> VITTORIE_1, 10 -> VITTORIE_2, 11 -> PAREGGI), push PARTITA into the FIFO, and transition to FINITA on the same edge.
REQ-020 If MANCHE!=00 and PARTITA!=00 arrive in the same cycle, SHALL apply both REQ-018 and REQ-019.
REQ-021 Match counters SHALL saturate at 15 and SHALL NOT wrap.
REQ-022 In FINITA, MANCHE and PARTITA SHALL be ignored and N_MANCHE SHALL hold; INIZIO=1 SHALL transition to IN_GIOCO and clear N_MANCHE.
REQ-023 In IN_GIOCO, INIZIO=1 SHALL take priority: N_MANCHE is cleared, the state stays IN_GIOCO, and any concurrent MANCHE/PARTITA is discarded (no count, no push).
REQ-024 The FIFO SHALL be 4 entries deep, 2 bits wide, and first-in first-out.
REQ-025 RD_REQ=1 with the FIFO non-empty SHALL present the oldest entry on HIST_DATA with HIST_VALID=1 on the next cycle (1-cycle latency) and remove that entry.
REQ-026 HIST_VALID SHALL be a one-cycle pulse per pop; HIST_DATA SHALL hold its last value when HIST_VALID=0.
REQ-027 RD_REQ with the FIFO empty SHALL be ignored: HIST_VALID=0 and no pointer change.
REQ-028 A push while full without a pop SHALL overwrite the oldest entry (drop oldest); the FIFO stays full.
REQ-029 A simultaneous push and pop SHALL do both: the pop returns the oldest entry and the occupancy is unchanged, including when full (no drop) and when empty (the pop is ignored and the push is stored).
REQ-030 HIST_EMPTY and HIST_FULL SHALL reflect the post-edge occupancy (0 and 4 respectively).

Reset
REQ-031 rst_n=0 at a clock edge SHALL force STATO=IDLE; VITTORIE_1, VITTORIE_2, PAREGGI and N_MANCHE to 0; HIST_DATA=00; HIST_VALID=0; HIST_EMPTY=1; HIST_FULL=0; and SHALL empty the FIFO.
REQ-032 Reset SHALL take priority over all other inputs, including mid-match and mid-pop.

Verification
REQ-033 Reset, then INIZIO=1, then MANCHE=01,10,11 on three cycles -> STATO=01, N_MANCHE=3, all match counters 0.
REQ-034 In IN_GIOCO, PARTITA=10 with MANCHE=10 -> VITTORIE_2=1, N_MANCHE incremented, STATO=10, HIST_EMPTY=0; further MANCHE=01 -> N_MANCHE unchanged.
REQ-035 Play 5 matches with results 01,10,11,01,10 and no reads, then RD_REQ high for 5 cycles -> HIST_DATA sequence 10,11,01,10 with a HIST_VALID pulse on each, the 5th request ignored, HIST_EMPTY=1.
REQ-036 With the FIFO full, push 11 while RD_REQ=1 -> the pop returns the oldest entry, HIST_FULL stays 1, and no entry is dropped.
REQ-037 Play 17 matches won by PRIMO -> VITTORIE_1 holds at 15.
REQ-038 Apply INIZIO=1 together with PARTITA=01 in IN_GIOCO -> VITTORIE_1 unchanged and N_MANCHE=0; apply rst_n=0 mid-match -> all REQ-031 values on the next edge.

Source files
------------

// File: rtl/partita_stats.sv
// rtl/partita_stats.sv - match statistics for the MorraCinese FSMD
// Tracks match state, round count, saturating win/draw counters and a 4-deep result history FIFO.
module partita_stats (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       INIZIO,
  input  logic [1:0] MANCHE,
  input  logic [1:0] PARTITA,
  input  logic       RD_REQ,
  output logic [3:0] VITTORIE_1,
  output logic [3:0] VITTORIE_2,
  output logic [3:0] PAREGGI,
  output logic [4:0] N_MANCHE,
  output logic [1:0] STATO,
  output logic [1:0] HIST_DATA,
  output logic       HIST_VALID,
  output logic       HIST_EMPTY,
  output logic       HIST_FULL
);

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    IN_GIOCO = 2'b01,
    FINITA   = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  n_manche_q, n_manche_d;
  logic [3:0]  vitt1_q, vitt1_d;
  logic [3:0]  vitt2_q, vitt2_d;
  logic [3:0]  pareggi_q, pareggi_d;
  logic [1:0]  mem_q [4];
  logic [1:0]  mem_d [4];
  logic [1:0]  rd_ptr_q, rd_ptr_d;
  logic [1:0]  wr_ptr_q, wr_ptr_d;
  logic [2:0]  count_q, count_d;
  logic [1:0]  hist_data_q, hist_data_d;
  logic        hist_valid_q, hist_valid_d;
  logic        empty_q, full_q;
  logic        push, pop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      n_manche_q   <= '0;
      vitt1_q      <= '0;
      vitt2_q      <= '0;
      pareggi_q    <= '0;
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      hist_data_q  <= '0;
      hist_valid_q <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_manche_q   <= n_manche_d;
      vitt1_q      <= vitt1_d;
      vitt2_q      <= vitt2_d;
      pareggi_q    <= pareggi_d;
      mem_q        <= mem_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      hist_data_q  <= hist_data_d;
      hist_valid_q <= hist_valid_d;
      empty_q      <= (count_d == 3'd0);
      full_q       <= (count_d == 3'd4);
    end
  end

  always_comb begin
    state_d      = state_q;
    n_manche_d   = n_manche_q;
    vitt1_d      = vitt1_q;
    vitt2_d      = vitt2_q;
    pareggi_d    = pareggi_q;
    mem_d        = mem_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    hist_data_d  = hist_data_q;
    hist_valid_d = 1'b0;
    push         = 1'b0;
    pop          = RD_REQ && (count_q != 3'd0);

    case (state_q)
      IDLE, FINITA: begin
        if (INIZIO) begin
          state_d    = IN_GIOCO;
          n_manche_d = '0;
        end
      end
      IN_GIOCO: begin
        // A restart strobe discards any round/match result seen on the same edge
        if (INIZIO) begin
          n_manche_d = '0;
        end else begin
          if (MANCHE != 2'b00 && n_manche_q != 5'd31) n_manche_d = n_manche_q + 5'd1;
          if (PARTITA != 2'b00) begin
            push    = 1'b1;
            state_d = FINITA;
            case (PARTITA)
              2'b01:   if (vitt1_q != 4'hF) vitt1_d = vitt1_q + 4'd1;
              2'b10:   if (vitt2_q != 4'hF) vitt2_d = vitt2_q + 4'd1;
              2'b11:   if (pareggi_q != 4'hF) pareggi_d = pareggi_q + 4'd1;
              default: ;
            endcase
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      hist_data_d  = mem_q[rd_ptr_q];
      hist_valid_d = 1'b1;
      rd_ptr_d     = rd_ptr_q + 2'd1;
    end

    // When full, wr_ptr equals rd_ptr, so a push without a pop replaces the oldest entry
    if (push) begin
      mem_d[wr_ptr_q] = PARTITA;
      wr_ptr_d        = wr_ptr_q + 2'd1;
      if (count_q == 3'd4 && !pop) rd_ptr_d = rd_ptr_q + 2'd1;
    end

    case ({push, pop})
      2'b10:   if (count_q != 3'd4) count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: ;
    endcase
  end

  assign STATO      = state_q;
  assign N_MANCHE   = n_manche_q;
  assign VITTORIE_1 = vitt1_q;
  assign VITTORIE_2 = vitt2_q;
  assign PAREGGI    = pareggi_q;
  assign HIST_DATA  = hist_data_q;
  assign HIST_VALID = hist_valid_q;
  assign HIST_EMPTY = empty_q;
  assign HIST_FULL  = full_q;

endmodule

// File: tb/tb_partita_stats.sv
// tb/tb_partita_stats.sv - self-checking bench for partita_stats
// Queue-based reference model checked every cycle, plus directed literal checks.
module tb_partita_stats;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       INIZIO = 1'b0;
  logic [1:0] MANCHE = 2'b00;
  logic [1:0] PARTITA = 2'b00;
  logic       RD_REQ = 1'b0;
  logic [3:0] VITTORIE_1, VITTORIE_2, PAREGGI;
  logic [4:0] N_MANCHE;
  logic [1:0] STATO, HIST_DATA;
  logic       HIST_VALID, HIST_EMPTY, HIST_FULL;

  partita_stats dut (
    .clk(clk), .rst_n(rst_n), .INIZIO(INIZIO), .MANCHE(MANCHE), .PARTITA(PARTITA),
    .RD_REQ(RD_REQ), .VITTORIE_1(VITTORIE_1), .VITTORIE_2(VITTORIE_2), .PAREGGI(PAREGGI),
    .N_MANCHE(N_MANCHE), .STATO(STATO), .HIST_DATA(HIST_DATA), .HIST_VALID(HIST_VALID),
    .HIST_EMPTY(HIST_EMPTY), .HIST_FULL(HIST_FULL)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  bit chk_en = 1'b0;

  // Reference model: 0 idle, 1 playing, 2 finished
  int m_state = 0;
  int m_n = 0;
  int m_v1 = 0, m_v2 = 0, m_par = 0;
  int m_hdata = 0;
  int m_hvalid = 0;
  int m_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    bit do_push;
    do_push  = 1'b0;
    m_hvalid = 0;
    if (!rst_n) begin
      m_state = 0; m_n = 0; m_v1 = 0; m_v2 = 0; m_par = 0; m_hdata = 0;
      m_q.delete();
    end else begin
      if (m_state == 1) begin
        if (INIZIO) m_n = 0;
        else begin
          if (MANCHE != 0) m_n = (m_n < 31) ? m_n + 1 : 31;
          if (PARTITA != 0) begin
            do_push = 1'b1;
            m_state = 2;
            if (PARTITA == 1) m_v1 = (m_v1 < 15) ? m_v1 + 1 : 15;
            if (PARTITA == 2) m_v2 = (m_v2 < 15) ? m_v2 + 1 : 15;
            if (PARTITA == 3) m_par = (m_par < 15) ? m_par + 1 : 15;
          end
        end
      end else if (INIZIO) begin
        m_state = 1;
        m_n = 0;
      end
      if (RD_REQ && m_q.size() > 0) begin
        m_hdata  = m_q.pop_front();
        m_hvalid = 1;
      end
      if (do_push) begin
        if (m_q.size() == 4) void'(m_q.pop_front());
        m_q.push_back(int'(PARTITA));
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stato", int'(STATO), m_state);
      chk("n_manche", int'(N_MANCHE), m_n);
      chk("vittorie_1", int'(VITTORIE_1), m_v1);
      chk("vittorie_2", int'(VITTORIE_2), m_v2);
      chk("pareggi", int'(PAREGGI), m_par);
      chk("hist_valid", int'(HIST_VALID), m_hvalid);
      chk("hist_data", int'(HIST_DATA), m_hdata);
      chk("hist_empty", int'(HIST_EMPTY), int'(m_q.size() == 0));
      chk("hist_full", int'(HIST_FULL), int'(m_q.size() == 4));
    end
  end

  task automatic drive(input logic r, input logic ini, input logic [1:0] m,
                       input logic [1:0] p, input logic rd);
    rst_n = r; INIZIO = ini; MANCHE = m; PARTITA = p; RD_REQ = rd;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic play(input logic [1:0] res);
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 2'b00, res, 1'b0);
  endtask

  task automatic reset_dut();
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    drive(1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  logic [1:0] exp_pop [4];

  initial begin
    reset_dut();
    chk_en = 1'b1;
    chk("rst_stato", int'(STATO), 0);
    chk("rst_empty", int'(HIST_EMPTY), 1);
    chk("rst_full", int'(HIST_FULL), 0);
    chk("rst_hvalid", int'(HIST_VALID), 0);

    // Three valid rounds, no result
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 2'b11, 2'b00, 1'b0);
    chk("r33_stato", int'(STATO), 1);
    chk("r33_n", int'(N_MANCHE), 3);
    chk("r33_v1", int'(VITTORIE_1), 0);

    // Round and match result on the same edge, then ignored in FINITA
    drive(1'b1, 1'b0, 2'b10, 2'b10, 1'b0);
    chk("r34_v2", int'(VITTORIE_2), 1);
    chk("r34_n", int'(N_MANCHE), 4);
    chk("r34_stato", int'(STATO), 2);
    chk("r34_empty", int'(HIST_EMPTY), 0);
    drive(1'b1, 1'b0, 2'b01, 2'b01, 1'b0);
    chk("r34_hold_n", int'(N_MANCHE), 4);
    chk("r34_hold_v1", int'(VITTORIE_1), 0);

    // Five matches into a 4-deep FIFO drops the oldest
    reset_dut();
    play(2'b01); play(2'b10); play(2'b11); play(2'b01); play(2'b10);
    chk("r35_full", int'(HIST_FULL), 1);
    exp_pop[0] = 2'b10; exp_pop[1] = 2'b11; exp_pop[2] = 2'b01; exp_pop[3] = 2'b10;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
      chk("r35_valid", int'(HIST_VALID), 1);
      chk("r35_data", int'(HIST_DATA), int'(exp_pop[i]));
    end
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
    chk("r35_ign_valid", int'(HIST_VALID), 0);
    chk("r35_ign_data", int'(HIST_DATA), 2);
    chk("r35_ign_empty", int'(HIST_EMPTY), 1);
    drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b0);

    // Push and pop together while full
    play(2'b01); play(2'b10); play(2'b11); play(2'b01);
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 2'b11, 1'b1);
    chk("r36_valid", int'(HIST_VALID), 1);
    chk("r36_data", int'(HIST_DATA), 1);
    chk("r36_full", int'(HIST_FULL), 1);
    exp_pop[0] = 2'b10; exp_pop[1] = 2'b11; exp_pop[2] = 2'b01; exp_pop[3] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 2'b00, 2'b00, 1'b1);
      chk("r36_data_seq", int'(HIST_DATA), int'(exp_pop[i]));
    end
    chk("r36_empty", int'(HIST_EMPTY), 1);

    // Push and pop together while empty
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 2'b00, 2'b10, 1'b1);
    chk("empty_pp_valid", int'(HIST_VALID), 0);
    chk("empty_pp_empty", int'(HIST_EMPTY), 0);

    // INIZIO priority, then reset mid-match and mid-pop
    reset_dut();
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
    drive(1'b1, 1'b1, 2'b01, 2'b01, 1'b0);
    chk("r38_v1", int'(VITTORIE_1), 0);
    chk("r38_n", int'(N_MANCHE), 0);
    chk("r38_stato", int'(STATO), 1);
    chk("r38_empty", int'(HIST_EMPTY), 1);
    drive(1'b1, 1'b0, 2'b01, 2'b11, 1'b0);
    drive(1'b1, 1'b1, 2'b10, 2'b00, 1'b0);
    drive(1'b1, 1'b0, 2'b10, 2'b00, 1'b1);
    drive(1'b0, 1'b0, 2'b01, 2'b01, 1'b1);
    chk("r38_rst_stato", int'(STATO), 0);
    chk("r38_rst_par", int'(PAREGGI), 0);
    chk("r38_rst_n", int'(N_MANCHE), 0);
    chk("r38_rst_data", int'(HIST_DATA), 0);
    chk("r38_rst_empty", int'(HIST_EMPTY), 1);

    // Round counter saturates at 31
    drive(1'b1, 1'b1, 2'b00, 2'b00, 1'b0);
    for (int i = 0; i < 33; i++) drive(1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
    chk("n_sat", int'(N_MANCHE), 31);

    // Match counter saturates at 15
    reset_dut();
    for (int i = 0; i < 17; i++) play(2'b01);
    chk("r37_v1", int'(VITTORIE_1), 15);
    chk("r37_full", int'(HIST_FULL), 1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
